// File: rtl/shift_chain_monitor_if.sv
// ============================================================================
// shift_chain_monitor_if : control/status and chain bundle for shift_chain_monitor
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface shift_chain_monitor_if #(
   parameter int CNT_W = 16
);
   logic             enable;
   logic [1:0]       mode;
   logic             clear;
   logic             chain_q;
   logic             chain_d;
   logic             checking;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic             sat;

   modport master (
      output enable, mode, clear, chain_q,
      input  chain_d, checking, err_pulse, err_count, sat
   );

   modport slave (
      input  enable, mode, clear, chain_q,
      output chain_d, checking, err_pulse, err_count, sat
   );
endinterface

`default_nettype wire

// File: rtl/shift_chain_monitor.sv
// ============================================================================
// shift_chain_monitor : drives a test pattern into an external shift chain and
// counts mismatches on the returned bit. Define SHIFT_CHAIN_MONITOR_PRBS_EN
// to build the PRBS7 generator for mode 3 (otherwise mode 3 = alternating).
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module shift_chain_monitor #(
   parameter int CHAIN_LEN = 17,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   shift_chain_monitor_if.slave bus
);

   localparam int                c_FILL_W    = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;
   localparam logic [6:0]        c_LFSR_SEED = 7'h7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_load;
   logic                  w_run;
   logic [1:0]            w_mode;
   logic [1:0]            r_mode;
   logic [c_FILL_W-1:0]   r_fill_cnt;
   logic                  r_chain_d;
   logic                  w_first_bit;
   logic                  w_next_bit;
   logic [CHAIN_LEN-1:0]  r_hist;
   logic                  w_mismatch;
   logic                  r_err_pulse;
   logic [CNT_W-1:0]      r_err_count;
   logic                  r_sat;

`ifdef SHIFT_CHAIN_MONITOR_PRBS_EN
   assign w_mode = bus.mode;
`else
   // Without the LFSR, mode 3 is folded onto the alternating pattern everywhere
   assign w_mode = (bus.mode == 2'd3) ? 2'd2 : bus.mode;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // w_load: (re)enter FILL with a fresh pattern; w_run: advance the pattern
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_run       = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.enable) begin
               w_state_nxt = FILL;
               w_load      = 1'b1;
            end
         end
         FILL, CHECK: begin
            if (!bus.enable) begin
               w_state_nxt = IDLE;
            end else if (w_mode != r_mode) begin
               w_state_nxt = FILL;
               w_load      = 1'b1;
            end else begin
               w_run = 1'b1;
               if ((r_state == FILL) && (r_fill_cnt == c_FILL_LAST))
                  w_state_nxt = CHECK;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef SHIFT_CHAIN_MONITOR_PRBS_EN
   logic [6:0] r_lfsr;
   logic [6:0] w_lfsr_nxt;

   assign w_lfsr_nxt = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_lfsr <= c_LFSR_SEED;
      else if (w_run) r_lfsr <= w_lfsr_nxt;
      else            r_lfsr <= c_LFSR_SEED;
   end
`endif

   // Every non-zero pattern opens with a 1 (the PRBS seed MSB is also 1)
   assign w_first_bit = (w_mode != 2'd0);

   always_comb begin
      w_next_bit = 1'b0;
      case (r_mode)
         2'd0:    w_next_bit = 1'b0;
         2'd1:    w_next_bit = 1'b1;
`ifdef SHIFT_CHAIN_MONITOR_PRBS_EN
         2'd3:    w_next_bit = w_lfsr_nxt[6];
`endif
         default: w_next_bit = ~r_chain_d;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain_d  <= 1'b0;
         r_mode     <= 2'd0;
         r_fill_cnt <= '0;
      end else begin
         if (w_load) begin
            r_chain_d <= w_first_bit;
            r_mode    <= w_mode;
         end else if (w_run) begin
            r_chain_d <= w_next_bit;
         end else begin
            r_chain_d <= 1'b0;
         end

         if (!w_load && (r_state == FILL) && (w_state_nxt == FILL))
            r_fill_cnt <= r_fill_cnt + c_FILL_W'(1);
         else
            r_fill_cnt <= '0;
      end
   end

   // Oldest history bit lines up with what the chain returns this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_hist <= '0;
      else        r_hist <= {r_hist[CHAIN_LEN-2:0], r_chain_d};
   end

   assign w_mismatch = (r_state == CHECK) && (bus.chain_q != r_hist[CHAIN_LEN-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_pulse <= 1'b0;
         r_err_count <= '0;
         r_sat       <= 1'b0;
      end else begin
         r_err_pulse <= w_mismatch;
         if (bus.clear) begin
            r_err_count <= '0;
            r_sat       <= 1'b0;
         end else if (w_mismatch && (r_err_count != c_CNT_MAX)) begin
            r_err_count <= r_err_count + CNT_W'(1);
            if (r_err_count == (c_CNT_MAX - CNT_W'(1)))
               r_sat <= 1'b1;
         end
      end
   end

   assign bus.chain_d   = r_chain_d;
   assign bus.checking  = (r_state == CHECK);
   assign bus.err_pulse = r_err_pulse;
   assign bus.err_count = r_err_count;
   assign bus.sat       = r_sat;

endmodule

`default_nettype wire
